uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver: next generation of the fixed 8N1 receive path in uart_test.

---
 rtl/uart_rx_cfg_pkg.sv | 32 +++
 rtl/uart_rx_cfg_bit_timer.sv | 33 +++
 rtl/uart_rx_cfg.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_cfg_pkg.sv
// rtl/uart_rx_cfg_pkg.sv - parity codes, receiver FSM states and helpers shared by the UART blocks
package uart_rx_cfg_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Counter width able to hold CYC_BIT-1 (at least one bit).
    function automatic int timer_width(input int cyc_bit);
        return (cyc_bit > 1) ? $clog2(cyc_bit) : 1;
    endfunction

    function automatic logic parity_error(input int mode, input logic data_xor, input logic par_bit);
        logic sum;
        sum = data_xor ^ par_bit;
        case (mode)
            PARITY_ODD:  return ~sum;
            PARITY_EVEN: return sum;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_cfg_bit_timer.sv
// rtl/uart_rx_cfg_bit_timer.sv - loadable bit-period down-counter with expiry pulse
module uart_rx_cfg_bit_timer
    import uart_rx_cfg_pkg::*;
#(
    parameter int CYC_BIT = 434,
    parameter int W       = timer_width(CYC_BIT)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    localparam logic [W-1:0] RELOAD = W'(CYC_BIT - 1);

    logic [W-1:0] cnt;

    // Auto-reload on expiry keeps every bit exactly CYC_BIT cycles from the first centre.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - W'(1);
        end
    end

    assign expire = en && !load && (cnt == '0);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with mid-bit sampling, valid/ready output and error flags
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 break_det
);

    localparam int             CYC_BIT  = CLK_FREQ / BAUD;
    localparam int             TW       = timer_width(CYC_BIT);
    localparam logic [TW-1:0]  HALF_BIT = TW'(CYC_BIT / 2);

    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_s_d;
    rx_state_t            state;
    rx_state_t            state_next;
    logic                 timer_load;
    logic                 timer_en;
    logic                 expire;
    logic                 frame_done;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic                 stop_any_low;
    logic                 stop_all_low;
    logic                 fall;
    logic                 fin_frame_err;
    logic                 fin_parity_err;
    logic                 fin_break;

    assign fall     = rx_s_d & ~rx_s;
    assign timer_en = (state != ST_IDLE) && (state != ST_BREAK);

    uart_rx_cfg_bit_timer #(
        .CYC_BIT (CYC_BIT),
        .W       (TW)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (timer_en),
        .load     (timer_load),
        .load_val (HALF_BIT),
        .expire   (expire)
    );

    // Frame verdict including the stop sample being taken this cycle.
    assign fin_frame_err  = stop_any_low | ~rx_s;
    assign fin_parity_err = parity_error(PARITY, ^shift_reg, par_bit);
    assign fin_break      = (shift_reg == '0) && !par_bit && stop_all_low && !rx_s;

    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    timer_load = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (expire) begin
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (expire && (bit_cnt == 4'(DATA_BITS - 1))) begin
                    state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (expire) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at the centre of the last stop bit so a back-to-back start edge is seen.
                if (expire && (stop_cnt == 1'(STOP_BITS - 1))) begin
                    frame_done = 1'b1;
                    state_next = fin_break ? ST_BREAK : ST_IDLE;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            rx_s_d       <= 1'b1;
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            shift_reg    <= '0;
            par_bit      <= 1'b0;
            stop_any_low <= 1'b0;
            stop_all_low <= 1'b1;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
            overrun_err  <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
            state   <= state_next;

            if (state == ST_IDLE && fall) begin
                bit_cnt      <= '0;
                stop_cnt     <= 1'b0;
                shift_reg    <= '0;
                par_bit      <= 1'b0;
                stop_any_low <= 1'b0;
                stop_all_low <= 1'b1;
            end
            if (expire) begin
                case (state)
                    ST_DATA: begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                    end
                    ST_PARITY: par_bit <= rx_s;
                    ST_STOP: begin
                        stop_cnt     <= stop_cnt + 1'b1;
                        stop_any_low <= stop_any_low | ~rx_s;
                        stop_all_low <= stop_all_low & ~rx_s;
                    end
                    default: ;
                endcase
            end

            // Acceptance in the completion cycle frees the holding register, so that is a load.
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
            if (frame_done) begin
                break_det <= fin_break;
                if (!rx_valid || rx_ready) begin
                    rx_valid   <= 1'b1;
                    rx_data    <= shift_reg;
                    frame_err  <= fin_frame_err;
                    parity_err <= fin_parity_err;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg (8N1 and 7E1 instances)
module tb_uart_rx_cfg;

    localparam int CYC  = 16;
    localparam int FREQ = 50_000_000;
    localparam int BAUD = FREQ / CYC;

    typedef struct packed {
        logic       pe;
        logic       fe;
        logic [8:0] data;
    } rx_rec_t;

    typedef struct {
        bit         sel;
        logic [8:0] data;
        logic       par;
        logic       stop;
        logic [8:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
        int         exp_brk;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line0 = 1'b1;
    logic       line1 = 1'b1;
    logic       ready0 = 1'b1;
    logic       ready1 = 1'b1;
    logic [7:0] data0;
    logic [6:0] data1;
    logic       valid0, valid1, fe0, fe1, pe0, pe1, ovr0, ovr1, brk0, brk1;

    rx_rec_t q0[$];
    rx_rec_t q1[$];
    int      brk_cnt0 = 0, brk_cnt1 = 0, ovr_cnt0 = 0, ovr_cnt1 = 0;
    int      n_pass = 0, n_total = 0;

    always #10 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line0), .rx_data(data0), .rx_valid(valid0),
        .rx_ready(ready0), .frame_err(fe0), .parity_err(pe0), .overrun_err(ovr0), .break_det(brk0)
    );

    uart_rx_cfg #(.CLK_FREQ(FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line1), .rx_data(data1), .rx_valid(valid1),
        .rx_ready(ready1), .frame_err(fe1), .parity_err(pe1), .overrun_err(ovr1), .break_det(brk1)
    );

    always @(negedge clk) begin
        if (valid0 && ready0) q0.push_back({pe0, fe0, 1'b0, data0});
        if (valid1 && ready1) q1.push_back({pe1, fe1, 2'b00, data1});
        if (brk0) brk_cnt0++;
        if (brk1) brk_cnt1++;
        if (ovr0) ovr_cnt0++;
        if (ovr1) ovr_cnt1++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) line1 = v;
        else line0 = v;
    endtask

    task automatic hold_bits(input bit sel, input logic v, input int nbits);
        set_line(sel, v);
        repeat (nbits * CYC) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [8:0] d, input logic par, input logic stop);
        int nb;
        nb = sel ? 7 : 8;
        hold_bits(sel, 1'b0, 1);
        for (int i = 0; i < nb; i++) hold_bits(sel, d[i], 1);
        if (sel) hold_bits(sel, par, 1);
        hold_bits(sel, stop, 1);
        set_line(sel, 1'b1);
    endtask

    task automatic expect_frame(input bit sel, input logic [8:0] d, input logic fe, input logic pe,
                                input int brk_before, input int exp_brk, input string nm);
        rx_rec_t r;
        int      n;
        n = sel ? q1.size() : q0.size();
        chk({nm, "_count"}, n, 1);
        if (n > 0) begin
            if (sel) r = q1.pop_front();
            else r = q0.pop_front();
            chk({nm, "_data"}, r.data, d);
            chk({nm, "_frame_err"}, r.fe, fe);
            chk({nm, "_parity_err"}, r.pe, pe);
        end
        if (sel) q1.delete();
        else q0.delete();
        chk({nm, "_break"}, (sel ? brk_cnt1 : brk_cnt0) - brk_before, exp_brk);
    endtask

    // Reference: frame outcome from the line-level rules, independent of receiver structure.
    function automatic logic model_pe(input bit sel, input logic [8:0] d, input logic par);
        int ones;
        if (!sel) return 1'b0;
        ones = $countones(d[6:0]) + int'(par);
        return (ones % 2) == 1;
    endfunction

    function automatic int model_brk(input bit sel, input logic [8:0] d, input logic par, input logic stop);
        if (sel) return (d[6:0] == 0 && !par && !stop) ? 1 : 0;
        return (d[7:0] == 0 && !stop) ? 1 : 0;
    endfunction

    initial begin
        vec_t vecs[10];
        int   b0;
        logic [8:0] d;
        logic p, s;
        bit   sel;

        vecs[0] = '{0, 9'h0A3, 0, 1, 9'h0A3, 0, 0, 0};
        vecs[1] = '{0, 9'h0A3, 0, 0, 9'h0A3, 1, 0, 0};
        vecs[2] = '{0, 9'h000, 0, 0, 9'h000, 1, 0, 1};
        vecs[3] = '{0, 9'h0FF, 0, 1, 9'h0FF, 0, 0, 0};
        vecs[4] = '{1, 9'h041, 1, 1, 9'h041, 0, 1, 0};
        vecs[5] = '{1, 9'h041, 0, 1, 9'h041, 0, 0, 0};
        vecs[6] = '{1, 9'h000, 0, 0, 9'h000, 1, 0, 1};
        vecs[7] = '{1, 9'h000, 1, 0, 9'h000, 1, 1, 0};
        vecs[8] = '{1, 9'h07F, 1, 1, 9'h07F, 0, 0, 0};
        vecs[9] = '{1, 9'h02A, 0, 1, 9'h02A, 0, 1, 0};

        repeat (4) @(negedge clk);
        chk("reset_valid0", valid0, 0);
        chk("reset_data0", data0, 0);
        chk("reset_flags0", {fe0, pe0, ovr0, brk0}, 0);
        chk("reset_valid1", valid1, 0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            b0 = vecs[i].sel ? brk_cnt1 : brk_cnt0;
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].stop);
            hold_bits(vecs[i].sel, 1'b1, 2);
            expect_frame(vecs[i].sel, vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_pe,
                         b0, vecs[i].exp_brk, $sformatf("vec%0d", i));
        end

        // Short glitch on an idle line must not produce a frame.
        line0 = 1'b0;
        repeat (5) @(negedge clk);
        line0 = 1'b1;
        repeat (3 * CYC) @(negedge clk);
        chk("glitch_no_frame", q0.size(), 0);
        b0 = brk_cnt0;
        send_frame(0, 9'h055, 0, 1);
        hold_bits(0, 1'b1, 2);
        expect_frame(0, 9'h055, 0, 0, b0, 0, "after_glitch");

        // Back-to-back frames with the consumer stalled.
        ready0 = 1'b0;
        b0 = ovr_cnt0;
        send_frame(0, 9'h012, 0, 1);
        send_frame(0, 9'h034, 0, 1);
        hold_bits(0, 1'b1, 2);
        chk("overrun_pulses", ovr_cnt0 - b0, 1);
        chk("overrun_valid_held", valid0, 1);
        chk("overrun_data_held", data0, 8'h12);
        ready0 = 1'b1;
        repeat (4) @(negedge clk);
        chk("overrun_valid_drop", valid0, 0);
        expect_frame(0, 9'h012, 0, 0, brk_cnt0, 0, "overrun_accept");

        // Long break: one report, no re-trigger while the line stays low.
        b0 = brk_cnt0;
        hold_bits(0, 1'b0, 12);
        hold_bits(0, 1'b1, 3);
        expect_frame(0, 9'h000, 1, 0, b0, 1, "long_break");

        // Reset in the middle of a frame discards it.
        hold_bits(0, 1'b0, 1);
        for (int i = 0; i < 4; i++) hold_bits(0, 1'(8'h77 >> i), 1);
        rst_n = 1'b0;
        line0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_valid", valid0, 0);
        chk("midreset_data", data0, 0);
        chk("midreset_flags", {fe0, pe0, ovr0, brk0}, 0);
        rst_n = 1'b1;
        repeat (6 * CYC) @(negedge clk);
        chk("midreset_no_frame", q0.size(), 0);
        chk("midreset_valid_after", valid0, 0);

        // Random frames on both instances against the line-level model.
        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom_range(0, 1));
            d   = 9'($urandom) & (sel ? 9'h07F : 9'h0FF);
            if ($urandom_range(0, 7) == 0) d = '0;
            p   = 1'($urandom_range(0, 1));
            s   = ($urandom_range(0, 3) != 0);
            b0  = sel ? brk_cnt1 : brk_cnt0;
            send_frame(sel, d, p, s);
            hold_bits(sel, 1'b1, 2);
            expect_frame(sel, d, ~s, model_pe(sel, d, p), b0, model_brk(sel, d, p, s),
                         $sformatf("rand%0d", i));
        end
        chk("no_overrun_dut1", ovr_cnt1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
